// File: rtl/eject_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | eject_arbiter : router ejection stage, 4 matched input holds, RR to PE   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module eject_arbiter #(
  parameter int FLIT_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FLIT_WIDTH-1:0] in_flit1,
  input  logic [FLIT_WIDTH-1:0] in_flit2,
  input  logic [FLIT_WIDTH-1:0] in_flit3,
  input  logic [FLIT_WIDTH-1:0] in_flit4,
  input  logic                  in_valid1,
  input  logic                  in_valid2,
  input  logic                  in_valid3,
  input  logic                  in_valid4,
  input  logic                  match1,
  input  logic                  match2,
  input  logic                  match3,
  input  logic                  match4,
  output logic                  in_ready1,
  output logic                  in_ready2,
  output logic                  in_ready3,
  output logic                  in_ready4,
  output logic [FLIT_WIDTH-1:0] out_flit,
  output logic [1:0]            out_port,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_WIDTH-1:0]  eject_count
);

  localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = {CNT_WIDTH{1'b1}};

  logic [FLIT_WIDTH-1:0] w_flit [4];
  logic [3:0]            w_in_valid;
  logic [3:0]            w_match;
  logic [3:0]            w_in_ready;
  logic [3:0]            w_cap;
  logic [3:0]            w_grant;
  logic                  w_free;
  logic                  w_any;
  logic [1:0]            w_sel;

  logic [FLIT_WIDTH-1:0] r_hold [4];
  logic [3:0]            r_hold_valid;
  logic [1:0]            r_rr;
  logic [FLIT_WIDTH-1:0] r_out_flit;
  logic [1:0]            r_out_port;
  logic                  r_out_valid;
  logic [CNT_WIDTH-1:0]  r_count;

  assign w_flit[0]  = in_flit1;
  assign w_flit[1]  = in_flit2;
  assign w_flit[2]  = in_flit3;
  assign w_flit[3]  = in_flit4;
  assign w_in_valid = {in_valid4, in_valid3, in_valid2, in_valid1};
  assign w_match    = {match4, match3, match2, match1};

  assign w_free = ~r_out_valid | out_ready;

  // Round-robin search starting at r_rr; first held flit found wins.
  always_comb begin
    w_any = 1'b0;
    w_sel = 2'd0;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] idx;
      idx = r_rr + 2'(k);
      if (!w_any && r_hold_valid[idx]) begin
        w_any = 1'b1;
        w_sel = idx;
      end
    end
  end

  always_comb begin
    w_grant = 4'd0;
    if (w_free && w_any) begin
      w_grant[w_sel] = 1'b1;
    end
  end

  assign w_in_ready = ~r_hold_valid | w_grant;
  assign w_cap      = w_in_valid & w_match & w_in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_valid <= 4'd0;
      for (int i = 0; i < 4; i++) begin
        r_hold[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_cap[i]) begin
          r_hold[i]       <= w_flit[i];
          r_hold_valid[i] <= 1'b1;
        end else if (w_grant[i]) begin
          r_hold_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Output register only loads on a grant, so it stays put under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_flit  <= '0;
      r_out_port  <= 2'd0;
      r_out_valid <= 1'b0;
      r_rr        <= 2'd0;
    end else if (w_free && w_any) begin
      r_out_flit  <= r_hold[w_sel];
      r_out_port  <= w_sel;
      r_out_valid <= 1'b1;
      r_rr        <= w_sel + 2'd1;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (r_out_valid && out_ready && (r_count != c_CNT_MAX)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign in_ready1   = w_in_ready[0];
  assign in_ready2   = w_in_ready[1];
  assign in_ready3   = w_in_ready[2];
  assign in_ready4   = w_in_ready[3];
  assign out_flit    = r_out_flit;
  assign out_port    = r_out_port;
  assign out_valid   = r_out_valid;
  assign eject_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_eject_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_eject_arbiter : directed vectors for eject_arbiter                    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_eject_arbiter;

  logic        clk;
  logic        rst_n;
  logic [15:0] flit [4];
  logic [3:0]  vld;
  logic [3:0]  mt;
  logic        out_ready;

  wire  [3:0]  rdy;
  wire  [15:0] out_flit;
  wire  [1:0]  out_port;
  wire         out_valid;
  wire  [15:0] cnt;

  wire  [3:0]  rdy4;
  wire  [15:0] out_flit4;
  wire  [1:0]  out_port4;
  wire         out_valid4;
  wire  [3:0]  cnt4;

  int n_vec = 0;
  int n_err = 0;

  eject_arbiter #(.FLIT_WIDTH(16), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_flit1(flit[0]), .in_flit2(flit[1]), .in_flit3(flit[2]), .in_flit4(flit[3]),
    .in_valid1(vld[0]), .in_valid2(vld[1]), .in_valid3(vld[2]), .in_valid4(vld[3]),
    .match1(mt[0]), .match2(mt[1]), .match3(mt[2]), .match4(mt[3]),
    .in_ready1(rdy[0]), .in_ready2(rdy[1]), .in_ready3(rdy[2]), .in_ready4(rdy[3]),
    .out_flit(out_flit), .out_port(out_port), .out_valid(out_valid),
    .out_ready(out_ready), .eject_count(cnt)
  );

  // Narrow-counter instance sees identical traffic to exercise saturation.
  eject_arbiter #(.FLIT_WIDTH(16), .CNT_WIDTH(4)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .in_flit1(flit[0]), .in_flit2(flit[1]), .in_flit3(flit[2]), .in_flit4(flit[3]),
    .in_valid1(vld[0]), .in_valid2(vld[1]), .in_valid3(vld[2]), .in_valid4(vld[3]),
    .match1(mt[0]), .match2(mt[1]), .match3(mt[2]), .match4(mt[3]),
    .in_ready1(rdy4[0]), .in_ready2(rdy4[1]), .in_ready3(rdy4[2]), .in_ready4(rdy4[3]),
    .out_flit(out_flit4), .out_port(out_port4), .out_valid(out_valid4),
    .out_ready(out_ready), .eject_count(cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    vld       = 4'd0;
    mt        = 4'd0;
    out_ready = 1'b0;
    for (int p = 0; p < 4; p++) flit[p] = 16'd0;

    // Power-on reset state
    #12;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_flit",  32'(out_flit),  32'd0);
    check("rst_port",  32'(out_port),  32'd0);
    check("rst_cnt",   32'(cnt),       32'd0);
    check("rst_ready", 32'(rdy),       32'hF);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // T2 single flit on port 2
    flit[1] = 16'hA5A5; vld = 4'b0010; mt = 4'b0010; out_ready = 1'b1;
    tick();
    vld = 4'd0; mt = 4'd0; flit[1] = 16'd0;
    tick();
    check("t2_valid", 32'(out_valid), 32'd1);
    check("t2_flit",  32'(out_flit),  32'hA5A5);
    check("t2_port",  32'(out_port),  32'd1);
    tick();
    check("t2_cnt",    32'(cnt),       32'd1);
    check("t2_drain",  32'(out_valid), 32'd0);

    // T3 valid but unmatched flits are ignored
    vld = 4'hF; mt = 4'h0;
    for (int p = 0; p < 4; p++) flit[p] = 16'hEE00 | 16'(p);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t3_ready", 32'(rdy), 32'hF);
    end
    check("t3_valid", 32'(out_valid), 32'd0);
    check("t3_cnt",   32'(cnt),       32'd1);

    // T1 reset mid-traffic with all holds full and output stalled
    out_ready = 1'b0; vld = 4'hF; mt = 4'hF;
    for (int p = 0; p < 4; p++) flit[p] = 16'hB000 | 16'(p);
    tick();
    tick();
    vld = 4'd0; mt = 4'd0;
    check("t1_pre_valid", 32'(out_valid), 32'd1);
    check("t1_pre_ready", 32'(rdy),       32'h0);
    #2 rst_n = 1'b0;
    #1;
    check("t1_valid", 32'(out_valid), 32'd0);
    check("t1_flit",  32'(out_flit),  32'd0);
    check("t1_port",  32'(out_port),  32'd0);
    check("t1_cnt",   32'(cnt),       32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("t1_ready", 32'(rdy), 32'hF);

    // T4 all ports matched every cycle: strict rotation, no gaps
    out_ready = 1'b1; vld = 4'hF; mt = 4'hF;
    for (int p = 0; p < 4; p++) flit[p] = 16'hC000 | 16'(p);
    tick();
    for (int i = 0; i < 8; i++) begin
      tick();
      check("t4_valid", 32'(out_valid), 32'd1);
      check("t4_port",  32'(out_port),  32'(i % 4));
      check("t4_flit",  32'(out_flit),  32'hC000 | 32'(i % 4));
    end
    vld = 4'd0; mt = 4'd0;
    repeat (5) tick();
    check("t4_idle", 32'(out_valid), 32'd0);
    check("t4_cnt",  32'(cnt),       32'd12);

    // T5 backpressure with ports 1 and 3 loaded
    out_ready = 1'b0;
    flit[0] = 16'h1111; flit[2] = 16'h3333; vld = 4'b0101; mt = 4'b0101;
    tick();
    flit[0] = 16'h1112;
    tick();
    vld = 4'd0; mt = 4'd0;
    check("t5_ready1", 32'(rdy[0]), 32'd0);
    check("t5_ready3", 32'(rdy[2]), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t5_hold_flit",  32'(out_flit),  32'h1111);
      check("t5_hold_port",  32'(out_port),  32'd0);
      check("t5_hold_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    tick();
    check("t5_port_b", 32'(out_port), 32'd2);
    check("t5_flit_b", 32'(out_flit), 32'h3333);
    tick();
    check("t5_port_c", 32'(out_port), 32'd0);
    check("t5_flit_c", 32'(out_flit), 32'h1112);
    tick();
    check("t5_idle",   32'(out_valid), 32'd0);
    check("t5_cnt",    32'(cnt),       32'd15);
    check("t5_cnt4",   32'(cnt4),      32'd15);

    // T6 twenty more flits: narrow counter must sit at 15
    flit[0] = 16'hD000; vld = 4'b0001; mt = 4'b0001;
    repeat (20) tick();
    vld = 4'd0; mt = 4'd0;
    repeat (3) tick();
    check("t6_idle", 32'(out_valid), 32'd0);
    check("t6_cnt",  32'(cnt),       32'd35);
    check("t6_sat",  32'(cnt4),      32'd15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
